// File: rtl/cordic_phase_gen.sv
// Phase accumulator with linear FTW sweep feeding the CORDIC z input (rotation mode).
// z_out/z_valid register one edge after en is sampled; out_valid trails z_valid by LATENCY cycles.
module cordic_phase_gen #(
    parameter int LATENCY = 19
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               phase_clr,
    input  logic [31:0]        ftw_in,
    input  logic               ftw_load,
    input  logic signed [15:0] phase_off,
    input  logic               sweep_en,
    input  logic signed [31:0] sweep_step,
    input  logic [31:0]        sweep_stop,
    output logic signed [15:0] z_out,
    output logic               mode_out,
    output logic               z_valid,
    output logic               out_valid,
    output logic               sweep_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [31:0]         r_acc;
    logic [31:0]         r_ftw;
    logic [31:0]         w_ftw_nxt;
    logic                w_done_nxt;
    logic [31:0]         w_acc_nxt;
    logic signed [33:0]  w_sum;
    logic signed [33:0]  w_stop_ext;
    logic                w_hit;
    logic signed [15:0]  r_z;
    logic                r_z_valid;
    logic                r_done;
    logic [LATENCY-1:0]  r_dly;

    assign w_acc_nxt = r_acc + r_ftw;

    // Two guard bits keep both a wrap past 2^32 and a dip below zero on the correct side of the stop value.
    assign w_sum      = $signed({2'b00, r_ftw}) + $signed({{2{sweep_step[31]}}, sweep_step});
    assign w_stop_ext = $signed({2'b00, sweep_stop});
    assign w_hit      = sweep_step[31] ? (w_sum <= w_stop_ext) : (w_sum >= w_stop_ext);

    always_comb begin
        w_state_nxt = r_state;
        w_ftw_nxt   = r_ftw;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (sweep_en) begin
                    w_state_nxt = S_SWEEP;
                end
            end
            S_SWEEP: begin
                if (!sweep_en) begin
                    w_state_nxt = S_IDLE;
                end else if (en && !ftw_load) begin
                    if (w_hit) begin
                        w_ftw_nxt   = sweep_stop;
                        w_state_nxt = S_HOLD;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_ftw_nxt = w_sum[31:0];
                    end
                end
            end
            S_HOLD: begin
                if (!sweep_en) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // A load overrides the sweep increment but leaves the sweep running from the new value.
        if (ftw_load) begin
            w_ftw_nxt = ftw_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ftw   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ftw   <= w_ftw_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_z       <= '0;
            r_z_valid <= 1'b0;
        end else begin
            r_z_valid <= en;
            if (phase_clr) begin
                r_acc <= '0;
                r_z   <= phase_off;
            end else if (en) begin
                r_acc <= w_acc_nxt;
                r_z   <= w_acc_nxt[31:16] + phase_off;
            end
        end
    end

    generate
        if (LATENCY == 1) begin : g_dly_one
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_dly <= '0;
                end else begin
                    r_dly <= r_z_valid;
                end
            end
        end else begin : g_dly_many
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_dly <= '0;
                end else begin
                    r_dly <= {r_dly[LATENCY-2:0], r_z_valid};
                end
            end
        end
    endgenerate

    assign z_out      = r_z;
    assign z_valid    = r_z_valid;
    assign out_valid  = r_dly[LATENCY-1];
    assign sweep_done = r_done;
    assign mode_out   = 1'b0;

endmodule
